// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the trace capture controller.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLDOFF = 2'd2
    } capture_state_t;

    // A programmed length of zero means capture until the enable drops.
    localparam int CAPTURE_LEN_UNLIMITED = 0;

endpackage

// File: rtl/trace_capture_if.sv
// Trigger, trace-stream and FIFO-side signals of the capture controller.
interface trace_capture_if #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
);
    logic               I_capture_enable;
    logic               I_abort;
    logic [COUNT_W-1:0] I_capture_len;
    logic               I_data_valid;
    logic [DATA_W-1:0]  I_data;
    logic               I_fifo_full;

    logic               O_capturing;
    logic               O_fifo_wr;
    logic [DATA_W-1:0]  O_fifo_data;
    logic [COUNT_W-1:0] O_count;
    logic               O_done;
    logic               O_overflow;
    logic               O_aborted;

    modport master (
        output I_capture_enable, I_abort, I_capture_len, I_data_valid, I_data, I_fifo_full,
        input  O_capturing, O_fifo_wr, O_fifo_data, O_count, O_done, O_overflow, O_aborted
    );

    modport slave (
        input  I_capture_enable, I_abort, I_capture_len, I_data_valid, I_data, I_fifo_full,
        output O_capturing, O_fifo_wr, O_fifo_data, O_count, O_done, O_overflow, O_aborted
    );

endinterface

// File: rtl/trace_capture_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Clear and increment together count the first item of a new run.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Capture-side controller: qualifies trace words into the capture FIFO, counts
// them against the programmed length and reports capture progress to the trigger.
module trace_capture_ctrl
    import trace_capture_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic            fe_clk,
    input  logic            reset_i,
    trace_capture_if.slave  bus
);

    capture_state_t     state_q, state_d;
    logic               capturing_q, capturing_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               abt_q, abt_d;

    logic               len_limited;
    logic               limit_hit;
    logic               accept;
    logic               start;
    logic               cnt_inc;
    logic [COUNT_W-1:0] count;

    // Greater-or-equal so that shrinking the length below the count also ends the run.
    assign len_limited = (bus.I_capture_len != COUNT_W'(CAPTURE_LEN_UNLIMITED));
    assign limit_hit   = len_limited && (count >= bus.I_capture_len);

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        abt_d   = abt_q;
        accept  = 1'b0;
        start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.I_capture_enable) begin
                    state_d = CAPTURE;
                    start   = 1'b1;
                    accept  = bus.I_data_valid;
                    ovf_d   = 1'b0;
                    abt_d   = 1'b0;
                end
            end
            CAPTURE: begin
                accept = bus.I_data_valid && !limit_hit;
                if (bus.I_abort) begin
                    state_d = HOLDOFF;
                    abt_d   = 1'b1;
                end else if (limit_hit || (!bus.I_capture_enable && !len_limited)) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!bus.I_capture_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_inc = accept && !bus.I_fifo_full;
        if (accept && bus.I_fifo_full) begin
            ovf_d = 1'b1;
        end

        wr_d   = cnt_inc;
        data_d = cnt_inc ? bus.I_data : data_q;

        // Capturing stays high through the cycle the end is decided, so the
        // trigger sees the falling edge together with the done pulse.
        capturing_d = (state_d == CAPTURE) || (state_q == CAPTURE);
        done_d      = (state_q == HOLDOFF) && capturing_q;
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            capturing_q <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            abt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            capturing_q <= capturing_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            abt_q       <= abt_d;
        end
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_count (
        .clk   (fe_clk),
        .rst   (reset_i),
        .clr   (start),
        .inc   (cnt_inc),
        .cnt_o (count)
    );

    assign bus.O_capturing = capturing_q;
    assign bus.O_fifo_wr   = wr_q;
    assign bus.O_fifo_data = data_q;
    assign bus.O_count     = count;
    assign bus.O_done      = done_q;
    assign bus.O_overflow  = ovf_q;
    assign bus.O_aborted   = abt_q;

endmodule

// File: doc/trace_capture_ctrl.md
# trace_capture_ctrl

Capture-side controller that answers the trigger block's capture-enable request. It qualifies incoming trace words into the capture FIFO, counts them against a programmed length and reports `O_capturing` back to the trigger block, so the trigger block sees a clean capturing high→low edge and ends its enable. It sits between the trigger block, the front-end trace word stream and the capture FIFO, all in the `fe_clk` domain.

## Interface
- `DATA_W`, default 8: trace word width.
- `COUNT_W`, default 16: capture length and count width.

Ports:
- `fe_clk`  in  1  front-end clock; all logic is rising-edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `I_capture_enable`  in  1  capture request from the trigger block; may be combinational from the match.
- `I_abort`  in  1  software abort of the current capture.
- `I_capture_len`  in  COUNT_W  number of words to capture; 0 means unlimited.
- `I_data_valid`  in  1  trace word valid.
- `I_data`  in  DATA_W  trace word.
- `I_fifo_full`  in  1  capture FIFO full.
- `O_capturing`  out  1  capture in progress; registered.
- `O_fifo_wr`  out  1  FIFO write strobe; registered.
- `O_fifo_data`  out  DATA_W  FIFO write data; registered with `O_fifo_wr`.
- `O_count`  out  COUNT_W  words written in the current or last capture.
- `O_done`  out  1  single-cycle pulse at capture end.
- `O_overflow`  out  1  sticky flag: a word was dropped because the FIFO was full.
- `O_aborted`  out  1  sticky flag: the last capture ended by abort.

## Operation
- States: IDLE, CAPTURE, HOLDOFF.
- **IDLE:**
  - `I_capture_enable`=1 moves the block to CAPTURE.
  - On that same cycle, `O_count`, `O_overflow` and `O_aborted` clear.
  - A word that is valid on that same cycle is accepted. This is the match-cycle word.
- **CAPTURE:**
  - `O_capturing`=1.
  - A word is accepted when `I_data_valid` is high and the limit is not reached. The limit is reached when `I_capture_len`≠0 and `O_count`==`I_capture_len`.
- **Accepted word:**
  - If `I_fifo_full`=0: the word is written (`O_fifo_wr`=1 next cycle, data registered) and `O_count` increments.
  - If `I_fifo_full`=1: the word is dropped, `O_overflow` is set and `O_count` does not change.
- **CAPTURE→HOLDOFF** happens on any of the following; `O_done` pulses on the next cycle in every case:
  - the limit is reached (checked on the registered count);
  - `I_capture_enable` is low while `I_capture_len`=0;
  - `I_abort`=1, which also sets `O_aborted`.
- **HOLDOFF:**
  - `O_capturing`=0.
  - The block waits for `I_capture_enable`=0, then moves to IDLE.
  - This blocks re-triggering while the trigger block's enable is still latched.
- **Abort outside CAPTURE:** `I_abort` in IDLE or HOLDOFF has no effect.
- **Unlimited mode:** `O_count` saturates at all-ones and does not wrap.
- **Length changes:** a change to `I_capture_len` mid-capture takes effect on the next limit compare. If the new value is already below `O_count`, the capture ends.

## Timing
- **Reset values:**
  - State is IDLE.
  - `O_capturing`, `O_fifo_wr`, `O_done`, `O_overflow` and `O_aborted` are 0.
  - `O_count` and `O_fifo_data` are 0.
- Reset asserted mid-capture takes effect immediately. No `O_done` is produced and no in-flight write is completed.
- **Start latency:**
  - Enable sampled high at edge N → `O_capturing`=1 after edge N.
  - `O_capturing` is high for at least one cycle, including when `I_capture_len`=1.
- **Write latency:** one cycle from `I_data_valid` to `O_fifo_wr`/`O_fifo_data`.
- **End timing:**
  - Limit seen at edge M → `O_capturing`=0 and `O_done`=1 after edge M+1.
  - No writes are issued after the limit-reaching write.
- **Simultaneous events:**
  - Abort and limit on the same cycle: treated as an abort.
  - Valid word and abort on the same cycle: the word is written.
- **Steady-state throughput:** one word per cycle.

## Structure
- Shared package `trace_capture_pkg`:
  - state enum `capture_state_t` (IDLE, CAPTURE, HOLDOFF);
  - the unlimited-length constant `CAPTURE_LEN_UNLIMITED` = 0.
- One sub-module, `sat_counter`: parameterised width, clear, increment and saturation at all-ones. It is used for `O_count`.
- FSM, write-qualification logic and sticky flags live in the top module.

## Test plan
- **Basic length:** len=4, enable held, valid every cycle from the enable cycle → exactly 4 writes, including the match-cycle word. `O_count`=4, one `O_done`, `O_capturing` high for 5 cycles.
- **Overflow:** len=8, `I_fifo_full` high for 2 of the valid cycles → 8 writes total. The 2 full-cycle words are dropped, `O_overflow`=1, then cleared by the next capture start.
- **Unlimited mode:** len=0, enable high for 10 cycles, valid every cycle → 10 writes. The capture ends one cycle after enable falls. `O_count` saturates at 0xFFFF in a long run.
- **Re-trigger guard:** enable held high 3 cycles after `O_done` → block stays in HOLDOFF with no new capture. Enable low for 1 cycle, then high → new capture, `O_count` restarts at 0.
- **Abort:** `I_abort` at word 3 of a len=10 capture with valid on that cycle → word 3 is written. `O_aborted`=1, `O_done` pulses, `O_count`=3.
- **Reset mid-capture:** assert `reset_i` asynchronously between edges during CAPTURE → all outputs go to 0 immediately, no `O_done`. After release the block is in IDLE.
